binary_to_bcd_stream: RTL and testbench



---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_dabble_step.sv | 27 ++
 rtl/binary_to_bcd_stream.sv | 188 ++++++++++++++++++
 tb/tb_binary_to_bcd_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the streaming binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } conv_state_e;

  // Step counter width; never collapses to zero bits for tiny inputs.
  function automatic int step_cnt_width(input int bits_in);
    return (bits_in > 1) ? $clog2(bits_in) : 1;
  endfunction

  // Double-dabble pre-shift correction of one digit.
  function automatic bcd_digit_t dabble_adjust(input bcd_digit_t d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: correct every digit, then shift the
// new binary bit into digit 0. Bit 3 of the corrected top digit is the carry
// that falls off the accumulator, i.e. the value no longer fits.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int BCD_DIGITS = 5
) (
  input  logic [4*BCD_DIGITS-1:0] acc_i,
  input  logic                    bit_i,
  output logic [4*BCD_DIGITS-1:0] acc_o,
  output logic                    ovf_o
);

  logic [4*BCD_DIGITS-1:0] adj;

  // Correct all digits, then shift left with the new bit entering at the bottom.
  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[4*i +: 4] = dabble_adjust(acc_i[4*i +: 4]);
    end
    ovf_o = adj[4*BCD_DIGITS-1];
    acc_o = {adj[4*BCD_DIGITS-2:0], bit_i};
  end

endmodule

// File: rtl/binary_to_bcd_stream.sv
// Handshaked iterative binary-to-BCD converter (double dabble).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a new operand; accepts on in_valid_i without ce_i
// CONV  | BITS_PER_CYCLE dabble steps per ce_i-high cycle
// HOLD  | result presented on out_valid_o until out_ready_i
module binary_to_bcd_stream
  import bcd_pkg::*;
#(
  parameter int BITS_IN        = 16,
  parameter int BCD_DIGITS     = 5,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED_IN      = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    ce_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [BITS_IN-1:0]      dat_binary_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [4*BCD_DIGITS-1:0] dat_bcd_o,
  output logic                    sign_o,
  output logic                    overflow_o,
  output logic                    busy_o
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = step_cnt_width(BITS_IN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS_IN - BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(BITS_PER_CYCLE);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (BITS_IN < BITS_PER_CYCLE) || ((BITS_IN % BITS_PER_CYCLE) != 0) ||
      (BCD_DIGITS < 1)) begin : g_bad_params
    $error("binary_to_bcd_stream: unsupported BITS_IN/BITS_PER_CYCLE/BCD_DIGITS");
  end

  conv_state_e        state_q, state_d;
  logic [BITS_IN-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_out_q, sign_out_d;
  logic               ovf_out_q, ovf_out_d;
  logic               out_valid_q, out_valid_d;

  logic [BITS_IN-1:0]        load_mag;
  logic                      load_sign;
  logic                      last_step;
  logic                      ovf_next;
  logic [BCD_W-1:0]          acc_step_in  [BITS_PER_CYCLE];
  logic [BCD_W-1:0]          acc_step_out [BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] ovf_chain;

  // Chained dabble steps; step g consumes magnitude bit BITS_IN-1-g.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    if (g == 0) begin : g_first
      assign acc_step_in[g] = acc_q;
    end else begin : g_next
      assign acc_step_in[g] = acc_step_out[g-1];
    end
    bcd_dabble_step #(
      .BCD_DIGITS(BCD_DIGITS)
    ) u_step (
      .acc_i(acc_step_in[g]),
      .bit_i(mag_q[BITS_IN-1-g]),
      .acc_o(acc_step_out[g]),
      .ovf_o(ovf_chain[g])
    );
  end

  // Sign/magnitude of the incoming operand; -2^(BITS_IN-1) maps to 2^(BITS_IN-1).
  always_comb begin
    load_sign = (SIGNED_IN != 0) && dat_binary_i[BITS_IN-1];
    load_mag  = load_sign ? (~dat_binary_i + BITS_IN'(1)) : dat_binary_i;
  end

  assign last_step = (cnt_q == LAST_CNT);

  // FSM next state; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid_i) state_d = CONV;
        CONV:    if (ce_i && last_step) state_d = HOLD;
        HOLD:    if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM-decoded handshake and status outputs.
  always_comb begin
    in_ready_o = (state_q == IDLE);
    busy_o     = (state_q == CONV);
  end

  // Datapath: operand load, per-cycle dabble steps and result capture.
  always_comb begin
    mag_d       = mag_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    bcd_d       = bcd_q;
    sign_out_d  = sign_out_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = out_valid_q;
    ovf_next    = ovf_q | (|ovf_chain);
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            mag_d  = load_mag;
            acc_d  = '0;
            ovf_d  = 1'b0;
            cnt_d  = '0;
            sign_d = load_sign;
          end
        end
        CONV: begin
          if (ce_i) begin
            mag_d = mag_q << BITS_PER_CYCLE;
            acc_d = acc_step_out[BITS_PER_CYCLE-1];
            ovf_d = ovf_next;
            if (last_step) begin
              cnt_d       = '0;
              bcd_d       = acc_step_out[BITS_PER_CYCLE-1];
              sign_out_d  = sign_q;
              ovf_out_d   = ovf_next;
              out_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_INC;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) out_valid_d = 1'b0;
        end
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      sign_out_q  <= 1'b0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
      sign_out_q  <= sign_out_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign dat_bcd_o   = bcd_q;
  assign sign_o      = sign_out_q;
  assign overflow_o  = ovf_out_q;

endmodule

// File: tb/tb_binary_to_bcd_stream.sv
// Scoreboard bench for binary_to_bcd_stream: 16-bit signed input, 4 digits,
// 2 steps per cycle, so overflow, sign handling and the step chain all matter.
module tb_binary_to_bcd_stream;

  localparam int BITS_IN = 16;
  localparam int DIGITS  = 4;
  localparam int BPC     = 2;
  localparam int STEPS   = BITS_IN / BPC;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic                sign;
    logic                ovf;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                ce_i, ce_dir, ce_rnd;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [BITS_IN-1:0]  dat;
  logic                out_valid;
  logic                out_ready, rdy_dir, rdy_rnd;
  logic [4*DIGITS-1:0] bcd;
  logic                sign;
  logic                ovf;
  logic                busy;
  logic                rnd_en;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  assign ce_i      = rnd_en ? ce_rnd  : ce_dir;
  assign out_ready = rnd_en ? rdy_rnd : rdy_dir;

  binary_to_bcd_stream #(
    .BITS_IN(BITS_IN),
    .BCD_DIGITS(DIGITS),
    .BITS_PER_CYCLE(BPC),
    .SIGNED_IN(1)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .ce_i(ce_i),
    .flush_i(flush),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .dat_binary_i(dat),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .dat_bcd_o(bcd),
    .sign_o(sign),
    .overflow_o(ovf),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed value -> sign, |value| mod 10^DIGITS in decimal digits.
  function automatic exp_t model(input logic [BITS_IN-1:0] d);
    exp_t e;
    int   v, mag, r, lim;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    v      = int'($signed(d));
    e.sign = (v < 0);
    mag    = (v < 0) ? -v : v;
    e.ovf  = (mag >= lim);
    r      = mag % lim;
    e.bcd  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random ce/out_ready generator used during the randomized phase.
  always @(posedge clk) begin
    #1;
    ce_rnd  = ($urandom_range(0, 3) != 0);
    rdy_rnd = ($urandom_range(0, 1) != 0);
  end

  // Monitor: a result handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("sign", 32'(sign), 32'(e.sign));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Present an operand and push its expected result once it is accepted.
  task automatic send(input logic [BITS_IN-1:0] d);
    bit acc;
    acc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    dat      = d;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(d));
        acc = 1;
        break;
      end
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic cycles_to_valid(output int cnt);
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid) break;
      ce_dir = ~ce_dir;
    end
  endtask

  logic [BITS_IN-1:0] corners [8];
  int                 cnt;

  initial begin
    corners = '{16'h0000, 16'h8000, 16'hFFFF, 16'd12345, 16'd9999,
                16'd10000, 16'h7FFF, 16'hD8F1};
    rnd_en = 1'b0; ce_dir = 1'b1; rdy_dir = 1'b0; flush = 1'b0;
    in_valid = 1'b0; dat = '0; rst_n = 1'b0;
    ce_rnd = 1'b1; rdy_rnd = 1'b0;

    #22;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency with ce high, then backpressure in HOLD.
    send(16'd12345);
    check("busy_in_conv", 32'(busy), 32'd1);
    check("ready_in_conv", 32'(in_ready), 32'd0);
    ce_dir = 1'b1;
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid) break;
    end
    check("latency", 32'(cnt), 32'(STEPS));
    check("busy_in_hold", 32'(busy), 32'd0);
    in_valid = 1'b1;
    dat      = 16'd1111;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_bcd", 32'(bcd), 32'h2345);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    rdy_dir  = 1'b1;
    @(posedge clk); #1;
    check("idle_after_release", 32'(in_ready), 32'd1);
    check("valid_after_release", 32'(out_valid), 32'd0);

    // Overflow flag must not stick across operands.
    send(16'd9999);
    drain();

    // ce toggling doubles the conversion time.
    rdy_dir = 1'b0;
    ce_dir  = 1'b0;
    send(16'h8000);
    cycles_to_valid(cnt);
    check("latency_ce_toggle", 32'(cnt), 32'(2 * STEPS));
    ce_dir  = 1'b1;
    rdy_dir = 1'b1;
    drain();

    // Asynchronous reset in the middle of a conversion.
    rdy_dir = 1'b0;
    send(16'h1234);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_sign", 32'(sign), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    rdy_dir = 1'b1;
    send(16'hFFFF);
    send(16'h0000);
    drain();

    // Flush in HOLD together with out_ready: flush wins, data retained.
    rdy_dir = 1'b0;
    send(16'd4321);
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid) break;
    end
    check("flush_setup_valid", 32'(out_valid), 32'd1);
    flush   = 1'b1;
    rdy_dir = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_bcd_kept", 32'(bcd), 32'h4321);
    sb.delete();

    // Randomized traffic with random ce and backpressure.
    rnd_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (n < 8) send(corners[n]);
      else send(BITS_IN'($urandom));
    end
    @(posedge clk); #1;
    rnd_en  = 1'b0;
    ce_dir  = 1'b1;
    rdy_dir = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
